// File: rtl/enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder:
// format codes, NOP word, burst FSM states and immediate ranges.
package enc_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Representable signed byte offsets per immediate format.
   localparam int signed IMM12_MIN = -2048;
   localparam int signed IMM12_MAX = 2047;
   localparam int signed IMMB_MIN  = -4096;
   localparam int signed IMMB_MAX  = 4094;
   localparam int signed IMMJ_MIN  = -1048576;
   localparam int signed IMMJ_MAX  = 1048574;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational immediate scatter for RV32I formats plus range flag.
// Range checking is built only when ENC_RANGE_CHECK_EN is defined.
module imm_pack
   import enc_pkg::*;
(
   input  logic [2:0]  fmt_i,
   input  logic [31:0] imm_i,
   output logic [31:0] imm_word_o,
   output logic        range_err_o
);

   always_comb begin
      imm_word_o = '0;
      unique case (fmt_e'(fmt_i))
         FMT_I:   imm_word_o = {imm_i[11:0], 20'b0};
         FMT_S:   imm_word_o = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
         FMT_B:   imm_word_o = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
         FMT_U:   imm_word_o = {imm_i[31:12], 12'b0};
         FMT_J:   imm_word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
         default: imm_word_o = '0;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   logic signed [31:0] imm_s;
   assign imm_s = signed'(imm_i);

   always_comb begin
      range_err_o = 1'b0;
      unique case (fmt_e'(fmt_i))
         FMT_I, FMT_S: range_err_o = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
         FMT_B:        range_err_o = (imm_s < IMMB_MIN) || (imm_s > IMMB_MAX) || imm_i[0];
         FMT_J:        range_err_o = (imm_s < IMMJ_MIN) || (imm_s > IMMJ_MAX) || imm_i[0];
         FMT_U:        range_err_o = (imm_i[11:0] != 12'b0);
         default:      range_err_o = 1'b0;
      endcase
   end
`else
   assign range_err_o = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Burst-framed RV32I instruction encoder with a registered valid/ready output.
// Immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder
   import enc_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2:0]        fmt_i,
   input  logic [6:0]        opcode_i,
   input  logic [4:0]        rd_i,
   input  logic [2:0]        func3_i,
   input  logic [4:0]        rs1_i,
   input  logic [4:0]        rs2_i,
   input  logic [6:0]        func7_i,
   input  logic [31:0]       imm_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [31:0]       word_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              err_o,
   output logic              busy_o,
   output logic              done_o
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  rem_q, rem_d, rem_issue_q, rem_issue_d;
   logic              out_valid_q, err_q;
   logic [31:0]       word_q;
   logic [ADDR_W-1:0] oaddr_q;

   logic [31:0] imm_word, word_d;
   logic        range_err, err_d;
   logic        accept, out_fire;

   assign out_fire   = out_valid_q && out_ready_i;
   assign in_ready_o = (state_q == ST_RUN) && (rem_issue_q != '0) && (!out_valid_q || out_ready_i);
   assign accept     = in_valid_i && in_ready_o;

   imm_pack u_imm_pack (
      .fmt_i       (fmt_i),
      .imm_i       (imm_i),
      .imm_word_o  (imm_word),
      .range_err_o (range_err)
   );

   logic [31:0] f_op, f_rd, f_f3, f_rs1, f_rs2, f_f7;
   assign f_op  = {25'b0, opcode_i};
   assign f_rd  = {20'b0, rd_i, 7'b0};
   assign f_f3  = {17'b0, func3_i, 12'b0};
   assign f_rs1 = {12'b0, rs1_i, 15'b0};
   assign f_rs2 = {7'b0, rs2_i, 20'b0};
   assign f_f7  = {func7_i, 25'b0};

   // Illegal formats override everything, including the range flag.
   always_comb begin
      word_d = imm_word | f_op;
      err_d  = range_err;
      unique case (fmt_e'(fmt_i))
         FMT_R:        word_d = imm_word | f_op | f_f7 | f_rs2 | f_rs1 | f_f3 | f_rd;
         FMT_I:        word_d = imm_word | f_op | f_rs1 | f_f3 | f_rd;
         FMT_S, FMT_B: word_d = imm_word | f_op | f_rs2 | f_rs1 | f_f3;
         FMT_U, FMT_J: word_d = imm_word | f_op | f_rd;
         default: begin
            word_d = NOP_WORD;
            err_d  = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      rem_issue_d = rem_issue_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               addr_d      = start_addr_i;
               rem_d       = len_i;
               rem_issue_d = len_i;
               state_d     = (len_i == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept) begin
               addr_d      = addr_q + ADDR_W'(4);
               rem_issue_d = rem_issue_q - LEN_W'(1);
            end
            if (out_fire) begin
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         rem_issue_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         rem_issue_q <= rem_issue_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         word_q      <= '0;
         oaddr_q     <= '0;
         err_q       <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         word_q      <= word_d;
         oaddr_q     <= addr_q;
         err_q       <= err_d;
      end else if (out_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid_o = out_valid_q;
   assign word_o      = word_q;
   assign addr_o      = oaddr_q;
   assign err_o       = err_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed table-driven bench for instr_encoder, plus hand sequences for
// zero-length bursts, backpressure, address wrap and mid-burst reset.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [31:0] start_addr_i;
   logic [15:0] len_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [2:0]  fmt_i;
   logic [6:0]  opcode_i;
   logic [4:0]  rd_i;
   logic [2:0]  func3_i;
   logic [4:0]  rs1_i;
   logic [4:0]  rs2_i;
   logic [6:0]  func7_i;
   logic [31:0] imm_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] word_o;
   logic [31:0] addr_o;
   logic        err_o;
   logic        busy_o;
   logic        done_o;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(32), .LEN_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .start_addr_i (start_addr_i),
      .len_i        (len_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .fmt_i        (fmt_i),
      .opcode_i     (opcode_i),
      .rd_i         (rd_i),
      .func3_i      (func3_i),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .func7_i      (func7_i),
      .imm_i        (imm_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .word_o       (word_o),
      .addr_o       (addr_o),
      .err_o        (err_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

`ifdef ENC_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] word;
      logic        err;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic apply(input vec_t v);
      in_valid_i = 1'b1;
      fmt_i      = v.fmt;
      opcode_i   = v.op;
      rd_i       = v.rd;
      func3_i    = v.f3;
      rs1_i      = v.rs1;
      rs2_i      = v.rs2;
      func7_i    = v.f7;
      imm_i      = v.imm;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_burst(input logic [31:0] a, input logic [15:0] n);
      start_i      = 1'b1;
      start_addr_i = a;
      len_i        = n;
      tick();
      start_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //           name       fmt  op     rd  f3  rs1 rs2 f7     imm           word          err
      vecs[0]  = '{"i_addi",  3'd1, 7'h13, 1, 0, 0, 0, 7'h00, 32'd5,        32'h0050_0093, 1'b0};
      vecs[1]  = '{"s_sw",    3'd2, 7'h23, 0, 2, 1, 2, 7'h00, 32'd8,        32'h0020_A423, 1'b0};
      vecs[2]  = '{"b_beq",   3'd3, 7'h63, 0, 0, 0, 0, 7'h00, -32'sd4,      32'hFE00_0EE3, 1'b0};
      vecs[3]  = '{"j_jal",   3'd5, 7'h6F, 1, 0, 0, 0, 7'h00, 32'd2048,     32'h0010_00EF, 1'b0};
      vecs[4]  = '{"r_sub",   3'd0, 7'h33, 3, 0, 1, 2, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 1'b0};
      vecs[5]  = '{"u_lui",   3'd4, 7'h37, 5, 0, 0, 0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0};
      vecs[6]  = '{"ill7",    3'd7, 7'h33, 3, 1, 1, 2, 7'h7F, 32'h0000_0800, 32'h0000_0013, 1'b1};
      vecs[7]  = '{"ill6",    3'd6, 7'h13, 1, 0, 0, 0, 7'h00, 32'd0,        32'h0000_0013, 1'b1};
      vecs[8]  = '{"i_2048",  3'd1, 7'h13, 1, 0, 0, 0, 7'h00, 32'd2048,     32'h8000_0093, RC};
      vecs[9]  = '{"b_odd",   3'd3, 7'h63, 0, 0, 0, 0, 7'h00, 32'd3,        32'h0000_0163, RC};
      vecs[10] = '{"i_neg1",  3'd1, 7'h13, 2, 0, 0, 0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0113, 1'b0};
      vecs[11] = '{"j_neg2",  3'd5, 7'h6F, 0, 0, 0, 0, 7'h00, -32'sd2,      32'hFFFF_F06F, 1'b0};
      vecs[12] = '{"s_m2049", 3'd2, 7'h23, 0, 0, 0, 0, 7'h00, -32'sd2049,   32'h7E00_0FA3, RC};

      rst = 1'b1; start_i = 1'b0; start_addr_i = '0; len_i = '0;
      in_valid_i = 1'b0; fmt_i = '0; opcode_i = '0; rd_i = '0; func3_i = '0;
      rs1_i = '0; rs2_i = '0; func7_i = '0; imm_i = '0; out_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_busy",      32'(busy_o),      32'd0);
      chk("rst_done",      32'(done_o),      32'd0);
      chk("rst_in_ready",  32'(in_ready_o),  32'd0);
      chk("rst_word",      word_o,           32'd0);
      rst = 1'b0;
      tick();

      // Full table streamed as one burst with a free-running sink.
      start_burst(32'h0000_1000, 16'(NV));
      chk("tbl_busy", 32'(busy_o), 32'd1);
      for (int i = 0; i < NV; i++) begin
         apply(vecs[i]);
         #1;
         chk({vecs[i].name, "_ready"}, 32'(in_ready_o), 32'd1);
         tick();
         chk({vecs[i].name, "_valid"}, 32'(out_valid_o), 32'd1);
         chk({vecs[i].name, "_word"},  word_o, vecs[i].word);
         chk({vecs[i].name, "_addr"},  addr_o, 32'h0000_1000 + 32'(4 * i));
         chk({vecs[i].name, "_err"},   32'(err_o), 32'(vecs[i].err));
      end
      in_valid_i = 1'b0;
      tick();
      chk("tbl_done",      32'(done_o),      32'd1);
      chk("tbl_out_drain", 32'(out_valid_o), 32'd0);
      tick();
      chk("tbl_done_off",  32'(done_o), 32'd0);
      chk("tbl_idle",      32'(busy_o), 32'd0);

      // Zero-length burst.
      start_burst(32'h0000_0040, 16'd0);
      chk("len0_done",  32'(done_o),      32'd1);
      chk("len0_valid", 32'(out_valid_o), 32'd0);
      chk("len0_ready", 32'(in_ready_o),  32'd0);
      tick();
      chk("len0_done_off", 32'(done_o), 32'd0);
      chk("len0_idle",     32'(busy_o), 32'd0);

      // Backpressure: sink stalls three cycles with a word pending.
      start_burst(32'h0000_0200, 16'd3);
      out_ready_i = 1'b0;
      apply(vecs[0]);
      tick();
      chk("bp_w0_valid", 32'(out_valid_o), 32'd1);
      apply(vecs[1]);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp_hold_ready", 32'(in_ready_o), 32'd0);
         tick();
         chk("bp_hold_word", word_o, vecs[0].word);
         chk("bp_hold_addr", addr_o, 32'h0000_0200);
      end
      out_ready_i = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready_o), 32'd1);
      tick();
      chk("bp_w1_word", word_o, vecs[1].word);
      chk("bp_w1_addr", addr_o, 32'h0000_0204);
      apply(vecs[2]);
      tick();
      chk("bp_w2_word", word_o, vecs[2].word);
      chk("bp_w2_addr", addr_o, 32'h0000_0208);
      apply(vecs[3]);
      #1;
      chk("bp_no_extra_beat", 32'(in_ready_o), 32'd0);
      tick();
      in_valid_i = 1'b0;
      chk("bp_done",       32'(done_o),      32'd1);
      chk("bp_out_clear",  32'(out_valid_o), 32'd0);
      tick();

      // Address wraps to zero without error.
      start_burst(32'hFFFF_FFFC, 16'd2);
      apply(vecs[0]);
      tick();
      chk("wrap_a0", addr_o, 32'hFFFF_FFFC);
      apply(vecs[10]);
      tick();
      chk("wrap_a1",    addr_o, 32'h0000_0000);
      chk("wrap_err",   32'(err_o), 32'd0);
      chk("wrap_word",  word_o, vecs[10].word);
      in_valid_i = 1'b0;
      tick();
      chk("wrap_done", 32'(done_o), 32'd1);
      tick();

      // Asynchronous reset in the middle of a burst.
      start_burst(32'h0000_0300, 16'd3);
      apply(vecs[5]);
      tick();
      chk("mid_valid_pre", 32'(out_valid_o), 32'd1);
      in_valid_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
      chk("mid_rst_busy",  32'(busy_o),      32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_ready", 32'(in_ready_o), 32'd0);
      chk("post_rst_done",  32'(done_o),     32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
